// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the decoded-control bundle handed from
// alu_ctrl_dec to the issue stage.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic { BSEL_RT, BSEL_IMM } bsel_e;
  typedef enum logic { EXT_SIGN, EXT_ZERO } ext_e;

  typedef struct packed {
    logic [2:0] f;
    bsel_e      bsel;
    ext_e       ext;
    logic       regwrite;
    logic       dst_rd;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       illegal;
  } dec_t;
endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational instruction decoder: ALU function, operand-B source/extension
// and writeback/memory controls. Undecodable instructions come out as a NOP.
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [5:0] op, funct;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    dec = '0;
    unique case (op)
      OP_RTYPE: begin
        dec.regwrite = 1'b1;
        dec.dst_rd   = 1'b1;
        unique case (funct)
          FN_ADD:  dec.f = ALU_ADD;
          FN_SUB:  dec.f = ALU_SUB;
          FN_AND:  dec.f = ALU_AND;
          FN_OR:   dec.f = ALU_OR;
          FN_SLT:  dec.f = ALU_SLT;
          default: begin
            dec         = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin dec.f = ALU_ADD; dec.bsel = BSEL_IMM; dec.regwrite = 1'b1; end
      OP_SLTI: begin dec.f = ALU_SLT; dec.bsel = BSEL_IMM; dec.regwrite = 1'b1; end
      OP_ANDI: begin
        dec.f = ALU_AND; dec.bsel = BSEL_IMM; dec.ext = EXT_ZERO; dec.regwrite = 1'b1;
      end
      OP_ORI: begin
        dec.f = ALU_OR; dec.bsel = BSEL_IMM; dec.ext = EXT_ZERO; dec.regwrite = 1'b1;
      end
      OP_LW: begin
        dec.f = ALU_ADD; dec.bsel = BSEL_IMM; dec.memread = 1'b1; dec.regwrite = 1'b1;
      end
      OP_SW:  begin dec.f = ALU_ADD; dec.bsel = BSEL_IMM; dec.memwrite = 1'b1; end
      OP_BEQ: begin dec.f = ALU_SUB; dec.branch = 1'b1; end
      default: dec.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: operand-B mux and immediate extension in front of a
// single valid/ready pipeline slot with flush.
module alu_issue_stage
  import mips_pkg::*;
#(
  parameter int DW             = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_f,
  output logic          regwrite,
  output logic [4:0]    writereg,
  output logic          memread,
  output logic          memwrite,
  output logic [DW-1:0] st_data,
  output logic          branch,
  output logic          illegal
);
  dec_t          dec;
  logic [DW-1:0] imm_ext, b_d;
  logic [4:0]    wreg_d;
  logic          load, issue, valid_d, valid_q;
  logic [DW-1:0] a_q, b_q, st_q;
  logic [2:0]    f_q;
  logic [4:0]    wreg_q;
  logic          rw_q, mr_q, mw_q, br_q, ill_q;

  alu_ctrl_dec u_dec (.instr(instr), .dec(dec));

  assign imm_ext = (dec.ext == EXT_ZERO) ? {{(DW-16){1'b0}}, instr[15:0]}
                                         : {{(DW-16){instr[15]}}, instr[15:0]};
  assign b_d     = (dec.bsel == BSEL_IMM) ? imm_ext : rd2;
  assign wreg_d  = dec.illegal ? 5'd0 : (dec.dst_rd ? instr[15:11] : instr[20:16]);

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;
  // Dropped illegals still count as accepted; they just never become valid.
  assign issue    = load && (!dec.illegal || ILLEGAL_AS_NOP);

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (load)      valid_d = issue;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      st_q    <= '0;
      f_q     <= ALU_AND;
      wreg_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (issue && !flush) begin
        a_q    <= rd1;
        b_q    <= b_d;
        st_q   <= rd2;
        f_q    <= dec.f;
        wreg_q <= wreg_d;
        rw_q   <= dec.regwrite;
        mr_q   <= dec.memread;
        mw_q   <= dec.memwrite;
        br_q   <= dec.branch;
        ill_q  <= dec.illegal;
      end
    end
  end

  assign out_valid = valid_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_f     = f_q;
  assign regwrite  = rw_q;
  assign writereg  = wreg_q;
  assign memread   = mr_q;
  assign memwrite  = mw_q;
  assign st_data   = st_q;
  assign branch    = br_q;
  assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: both illegal-handling variants driven
// in parallel against a queue-based reference of the issue slot.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] instr, rd1, rd2;

  logic        in_ready1, out_valid1, regwrite1, memread1, memwrite1, branch1, illegal1;
  logic [31:0] alu_a1, alu_b1, st_data1;
  logic [2:0]  alu_f1;
  logic [4:0]  writereg1;
  logic        in_ready0, out_valid0, regwrite0, memread0, memwrite0, branch0, illegal0;
  logic [31:0] alu_a0, alu_b0, st_data0;
  logic [2:0]  alu_f0;
  logic [4:0]  writereg0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DW(32), .ILLEGAL_AS_NOP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .instr(instr),
    .rd1(rd1), .rd2(rd2), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_f(alu_f1), .regwrite(regwrite1),
    .writereg(writereg1), .memread(memread1), .memwrite(memwrite1), .st_data(st_data1),
    .branch(branch1), .illegal(illegal1));

  alu_issue_stage #(.DW(32), .ILLEGAL_AS_NOP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .instr(instr),
    .rd1(rd1), .rd2(rd2), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_f(alu_f0), .regwrite(regwrite0),
    .writereg(writereg0), .memread(memread0), .memwrite(memwrite0), .st_data(st_data0),
    .branch(branch0), .illegal(illegal0));

  typedef struct {
    logic [31:0] a, b, st;
    logic [2:0]  f;
    logic [4:0]  wr;
    logic        rw, mr, mw, br, ill;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_chk = 0, n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what the instruction means, straight from the ISA table.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] d1,
                                   input logic [31:0] d2);
    exp_t        e;
    logic [31:0] se, ze;
    se = 32'($signed(ins[15:0]));
    ze = {16'h0, ins[15:0]};
    e = '{a: d1, b: d2, st: d2, f: 3'd0, wr: ins[20:16], rw: 1'b0, mr: 1'b0, mw: 1'b0,
          br: 1'b0, ill: 1'b0};
    case (ins[31:26])
      6'h00: begin
        e.rw = 1'b1; e.wr = ins[15:11];
        case (ins[5:0])
          6'h20: e.f = 3'b010;
          6'h22: e.f = 3'b110;
          6'h24: e.f = 3'b000;
          6'h25: e.f = 3'b001;
          6'h2a: e.f = 3'b111;
          default: e.ill = 1'b1;
        endcase
      end
      6'h08: begin e.f = 3'b010; e.b = se; e.rw = 1'b1; end
      6'h0a: begin e.f = 3'b111; e.b = se; e.rw = 1'b1; end
      6'h0c: begin e.f = 3'b000; e.b = ze; e.rw = 1'b1; end
      6'h0d: begin e.f = 3'b001; e.b = ze; e.rw = 1'b1; end
      6'h23: begin e.f = 3'b010; e.b = se; e.rw = 1'b1; e.mr = 1'b1; end
      6'h2b: begin e.f = 3'b010; e.b = se; e.mw = 1'b1; end
      6'h04: begin e.f = 3'b110; e.br = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.f = 3'b000; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[11];
    logic [5:0] fns[6];
    logic [31:0] r;
    ops = '{6'h00, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h3f, 6'h11};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h07};
    r = $urandom;
    r[31:26] = ops[$urandom_range(0, 10)];
    if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 5)];
    return r;
  endfunction

  // Slot model: pop on consume, push on accept, flush discards everything.
  always @(posedge clk) begin
    if (reset) begin
      q1.delete();
      q0.delete();
    end else if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (in_valid && (q1.size() == 0 || out_ready)) begin
        if (q1.size() != 0) void'(q1.pop_front());
        q1.push_back(ref_dec(instr, rd1, rd2));
      end else if (q1.size() != 0 && out_ready) void'(q1.pop_front());
      if (in_valid && (q0.size() == 0 || out_ready)) begin
        if (q0.size() != 0) void'(q0.pop_front());
        if (!ref_dec(instr, rd1, rd2).ill) q0.push_back(ref_dec(instr, rd1, rd2));
      end else if (q0.size() != 0 && out_ready) void'(q0.pop_front());
    end
  end

  task automatic cmp_out(input string tag, input bit have, input exp_t e, input logic ov,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                         input logic [2:0] f, input logic [4:0] wr, input logic rw,
                         input logic mr, input logic mw, input logic br, input logic ill);
    check({tag, ".out_valid"}, 32'(ov), 32'(have));
    if (have) begin
      check({tag, ".alu_f"}, 32'(f), 32'(e.f));
      check({tag, ".regwrite"}, 32'(rw), 32'(e.rw));
      check({tag, ".memread"}, 32'(mr), 32'(e.mr));
      check({tag, ".memwrite"}, 32'(mw), 32'(e.mw));
      check({tag, ".branch"}, 32'(br), 32'(e.br));
      check({tag, ".illegal"}, 32'(ill), 32'(e.ill));
      if (!e.ill) begin
        check({tag, ".alu_a"}, a, e.a);
        check({tag, ".alu_b"}, b, e.b);
      end
      if (e.rw) check({tag, ".writereg"}, 32'(wr), 32'(e.wr));
      if (e.mw) check({tag, ".st_data"}, st, e.st);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cmp_out("nop", q1.size() != 0, q1.size() != 0 ? q1[0] : ref_dec(32'h0, 32'h0, 32'h0),
              out_valid1, alu_a1, alu_b1, st_data1, alu_f1, writereg1, regwrite1, memread1,
              memwrite1, branch1, illegal1);
      cmp_out("drop", q0.size() != 0, q0.size() != 0 ? q0[0] : ref_dec(32'h0, 32'h0, 32'h0),
              out_valid0, alu_a0, alu_b0, st_data0, alu_f0, writereg0, regwrite0, memread0,
              memwrite0, branch0, illegal0);
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] d1,
                     input logic [31:0] d2, input logic ordy, input logic fl);
    in_valid = iv; instr = ins; rd1 = d1; rd2 = d2; out_ready = ordy; flush = fl;
    #1;
    check("nop.in_ready", 32'(in_ready1), 32'(q1.size() == 0 || out_ready));
    check("drop.in_ready", 32'(in_ready0), 32'(q0.size() == 0 || out_ready));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instr = '0; rd1 = '0; rd2 = '0;
    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(out_valid1), 0);
    check("rst.alu_f", 32'(alu_f1), 0);
    check("rst.in_ready", 32'(in_ready1), 1);
    check("rst.alu_a", alu_a1, 0);
    check("rst.alu_b", alu_b1, 0);
    check("rst.st_data", st_data1, 0);
    check("rst.ctrl", {regwrite1, memread1, memwrite1, branch1, illegal1}, 0);
    check("rst.writereg", 32'(writereg1), 0);
    check("rst.drop.out_valid", 32'(out_valid0), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // add $3,$1,$2
    cyc(1'b1, rtype(1, 2, 3, 6'h20), 32'd5, 32'd7, 1'b1, 1'b0);
    check("add.alu_a", alu_a1, 32'd5);
    check("add.alu_b", alu_b1, 32'd7);
    check("add.alu_f", 32'(alu_f1), 32'b010);
    check("add.writereg", 32'(writereg1), 3);
    cyc(1'b1, itype(6'h08, 1, 4, 16'hFFFF), 32'd1, 32'd2, 1'b1, 1'b0);
    check("addi.alu_b", alu_b1, 32'hFFFF_FFFF);
    cyc(1'b1, itype(6'h0d, 1, 4, 16'hFFFF), 32'd1, 32'd2, 1'b1, 1'b0);
    check("ori.alu_b", alu_b1, 32'h0000_FFFF);
    cyc(1'b1, itype(6'h0a, 1, 4, 16'h8000), 32'd1, 32'd2, 1'b1, 1'b0);
    check("slti.alu_f", 32'(alu_f1), 32'b111);

    // stall three cycles, then a gap-free stream of four
    cyc(1'b1, rtype(5, 6, 7, 6'h22), 32'h11, 32'h22, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, rtype(8, 9, 10, 6'h25), 32'h33, 32'h44, 1'b0, 1'b0);
    check("stall.in_ready", 32'(in_ready1), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, itype(6'h23, 1, i + 1, 16'(i * 4)), 32'(100 + i), 32'h0, 1'b1, 1'b0);
      check("stream.out_valid", 32'(out_valid1), 1);
    end

    cyc(1'b1, rtype(1, 2, 3, 6'h24), 32'h5, 32'h6, 1'b1, 1'b1);
    check("flush.out_valid", 32'(out_valid1), 0);
    cyc(1'b1, itype(6'h2b, 1, 2, 16'd8), 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("sw.st_data", st_data1, 32'hDEAD_BEEF);
    check("sw.alu_b", alu_b1, 32'd8);
    check("sw.ctrl", {regwrite1, memwrite1}, 32'b01);

    cyc(1'b1, {6'h3f, 26'h0}, 32'h1, 32'h2, 1'b1, 1'b0);
    check("ill.nop.out_valid", 32'(out_valid1), 1);
    check("ill.nop.illegal", 32'(illegal1), 1);
    check("ill.drop.out_valid", 32'(out_valid0), 0);
    cyc(1'b1, rtype(1, 2, 0, 6'h20), 32'h1, 32'h2, 1'b1, 1'b0);
    check("r0.regwrite", 32'(regwrite1), 1);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
